// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg: encodings shared by the RAM arbiter, its clear engine and its bus interface.
// Revision: 1.0
package cpu_pkg;
    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] GRANT_NONE  = 2'd0;
    localparam logic [1:0] GRANT_CPU   = 2'd1;
    localparam logic [1:0] GRANT_DEBUG = 2'd2;
    localparam logic [1:0] GRANT_CLEAR = 2'd3;

    localparam logic [0:0] STATE_SERVE = 1'b0;
    localparam logic [0:0] STATE_CLEAR = 1'b1;
endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ram_arbiter_if: requester-side and RAM-side signals of the data RAM arbiter.
// Revision: 1.0
interface ram_arbiter_if
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
);
    logic                  cpuRequest;
    logic                  cpuStore;
    logic [ADDR_WIDTH-1:0] cpuAddress;
    logic [WORD_WIDTH-1:0] cpuData;
    logic [WORD_WIDTH-1:0] cpuResult;
    logic                  cpuStall;
    logic                  debugRequest;
    logic [ADDR_WIDTH-1:0] debugAddress;
    logic                  debugAck;
    logic [WORD_WIDTH-1:0] debugResult;
    logic                  clearStart;
    logic                  clearBusy;
    logic                  ramStore;
    logic [ADDR_WIDTH-1:0] ramAddress;
    logic [WORD_WIDTH-1:0] ramData;
    logic [WORD_WIDTH-1:0] ramResult;

    modport slave (
        input  cpuRequest, cpuStore, cpuAddress, cpuData,
        input  debugRequest, debugAddress, clearStart, ramResult,
        output cpuResult, cpuStall, debugAck, debugResult, clearBusy,
        output ramStore, ramAddress, ramData
    );

    modport master (
        output cpuRequest, cpuStore, cpuAddress, cpuData,
        output debugRequest, debugAddress, clearStart, ramResult,
        input  cpuResult, cpuStall, debugAck, debugResult, clearBusy,
        input  ramStore, ramAddress, ramData
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter_clear.sv
`default_nettype none
// ram_arbiter_clear: SERVE/CLEAR sequencer that walks every RAM word once, one per cycle.
// Revision: 1.0
module ram_arbiter_clear
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 256
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  clearStart_i,
    output logic      [ADDR_WIDTH-3:0] clearCount_o,
    output logic                       clearBusy_o
);
    localparam int                  CW     = ADDR_WIDTH - 2;
    localparam logic [CW-1:0]       C_LAST = CW'(DEPTH - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            STATE_SERVE: begin
                if (clearStart_i) state_d = STATE_CLEAR;
            end
            STATE_CLEAR: begin
                if (count_q == C_LAST) begin
                    state_d = STATE_SERVE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = STATE_SERVE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= STATE_SERVE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign clearCount_o = count_q;
    assign clearBusy_o  = (state_q == STATE_CLEAR);
endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ram_arbiter: shares the data RAM between CPU ME stage, debug read port and bulk-clear engine.
// Revision: 1.0
module ram_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    ram_arbiter_if.slave    bus
);
    localparam int            WW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] C_LIMIT = WW'(STARVE_LIMIT);

    logic [ADDR_WIDTH-3:0] clearCount;
    logic                  clearBusy;
    logic [1:0]            grant;
    logic                  debugPending;
    logic                  storeSel;
    logic [ADDR_WIDTH-1:0] addrSel;
    logic [WORD_WIDTH-1:0] dataSel;

    logic [WW-1:0]         waitCount_q, waitCount_d;
    logic                  debugAck_q, debugAck_d;
    logic [WORD_WIDTH-1:0] debugResult_q, debugResult_d;

    ram_arbiter_clear #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clear (
        .clock        (clock),
        .reset        (reset),
        .clearStart_i (bus.clearStart),
        .clearCount_o (clearCount),
        .clearBusy_o  (clearBusy)
    );

    // A request still high during its own ack cycle must not be granted again.
    always_comb begin
        debugPending = bus.debugRequest && !debugAck_q;
        grant        = GRANT_NONE;
        if (clearBusy)
            grant = GRANT_CLEAR;
        else if (debugPending && waitCount_q == C_LIMIT)
            grant = GRANT_DEBUG;
        else if (bus.cpuRequest)
            grant = GRANT_CPU;
        else if (debugPending)
            grant = GRANT_DEBUG;
    end

    always_comb begin
        storeSel = 1'b0;
        addrSel  = '0;
        dataSel  = '0;
        case (grant)
            GRANT_CPU: begin
                storeSel = bus.cpuStore;
                addrSel  = bus.cpuAddress;
                dataSel  = bus.cpuData;
            end
            GRANT_DEBUG: begin
                addrSel  = bus.debugAddress;
            end
            GRANT_CLEAR: begin
                storeSel = 1'b1;
                addrSel  = {clearCount, 2'b00};
            end
            default: begin
                storeSel = 1'b0;
            end
        endcase
    end

    always_comb begin
        waitCount_d = waitCount_q;
        if (!bus.debugRequest || grant == GRANT_DEBUG)
            waitCount_d = '0;
        else if (waitCount_q != C_LIMIT)
            waitCount_d = waitCount_q + 1'b1;

        debugAck_d    = (grant == GRANT_DEBUG);
        debugResult_d = (grant == GRANT_DEBUG) ? bus.ramResult : debugResult_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            waitCount_q   <= '0;
            debugAck_q    <= 1'b0;
            debugResult_q <= '0;
        end else begin
            waitCount_q   <= waitCount_d;
            debugAck_q    <= debugAck_d;
            debugResult_q <= debugResult_d;
        end
    end

    // Write enable is forced low for the whole reset pulse, not just after the edge.
    assign bus.ramStore    = storeSel && !reset;
    assign bus.ramAddress  = addrSel;
    assign bus.ramData     = dataSel;
    assign bus.cpuResult   = bus.ramResult;
    assign bus.cpuStall    = bus.cpuRequest && (grant != GRANT_CPU);
    assign bus.debugAck    = debugAck_q;
    assign bus.debugResult = debugResult_q;
    assign bus.clearBusy   = clearBusy;
endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter: directed vector table plus hand-written clear / reset / collision sequences.
module tb_ram_arbiter;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    logic [31:0] mem [256];
    int tests = 0;
    int fails = 0;

    ram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    ram_arbiter #(.ADDR_WIDTH(AW), .DEPTH(256), .STARVE_LIMIT(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (bus.ramStore) begin
            mem[bus.ramAddress[9:2]] <= bus.ramData;
        end
    end
    assign bus.ramResult = mem[bus.ramAddress[9:2]];

    typedef struct {
        logic        creq;
        logic        cst;
        logic [9:0]  caddr;
        logic [31:0] cdata;
        logic        dreq;
        logic [9:0]  daddr;
        logic        e_stall;
        logic        e_store;
        logic [9:0]  e_raddr;
        logic        e_ack;
        logic        chk_res;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cpuRequest   = 1'b0;
        bus.cpuStore     = 1'b0;
        bus.cpuAddress   = '0;
        bus.cpuData      = '0;
        bus.debugRequest = 1'b0;
        bus.debugAddress = '0;
        bus.clearStart   = 1'b0;
    endtask

    task automatic cpu_store(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        idle_inputs();
        bus.cpuRequest = 1'b1; bus.cpuStore = 1'b1; bus.cpuAddress = a; bus.cpuData = d;
        @(negedge clk);
        check($sformatf("store %h stall", a), {31'd0, bus.cpuStall}, 32'd0);
    endtask

    task automatic cpu_read(input logic [9:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        idle_inputs();
        bus.cpuRequest = 1'b1; bus.cpuAddress = a;
        @(negedge clk);
        check($sformatf("read %h stall", a), {31'd0, bus.cpuStall}, 32'd0);
        check($sformatf("read %h data", a), bus.cpuResult, exp);
    endtask

    // Counts clearBusy cycles from the cycle after the start edge; k==10 probes a CPU store.
    task automatic wait_clear(input string name);
        int n = 0;
        bit done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (!bus.clearBusy) begin
                done = 1;
            end else begin
                n++;
                if (k == 10) begin
                    check({name, " stall in clear"}, {31'd0, bus.cpuStall}, 32'd1);
                    check({name, " clear data"}, bus.ramData, 32'd0);
                end
                @(posedge clk); #1;
                idle_inputs();
                if (k == 9) begin
                    bus.cpuRequest = 1'b1; bus.cpuStore = 1'b1;
                    bus.cpuAddress = 10'h100; bus.cpuData = 32'hFFFF_FFFF;
                end
            end
        end
        check({name, " busy cycles"}, n, 32'd256);
    endtask

    initial begin
        idle_inputs();
        vecs[0]  = '{1,1,10'h010,32'hDEADBEEF, 0,10'h000, 0,1,10'h010,0, 0,32'h0};
        vecs[1]  = '{1,0,10'h010,32'h0,        0,10'h000, 0,0,10'h010,0, 1,32'hDEADBEEF};
        vecs[2]  = '{0,0,10'h000,32'h0,        1,10'h010, 0,0,10'h010,0, 1,32'hDEADBEEF};
        vecs[3]  = '{0,0,10'h000,32'h0,        1,10'h010, 0,0,10'h000,1, 0,32'h0};
        vecs[4]  = '{0,0,10'h000,32'h0,        0,10'h000, 0,0,10'h000,0, 0,32'h0};
        vecs[5]  = '{1,0,10'h010,32'h0,        1,10'h020, 0,0,10'h010,0, 1,32'hDEADBEEF};
        vecs[6]  = '{1,0,10'h010,32'h0,        1,10'h020, 0,0,10'h010,0, 0,32'h0};
        vecs[7]  = '{1,0,10'h010,32'h0,        1,10'h020, 0,0,10'h010,0, 0,32'h0};
        vecs[8]  = '{1,0,10'h010,32'h0,        1,10'h020, 0,0,10'h010,0, 0,32'h0};
        vecs[9]  = '{1,0,10'h010,32'h0,        1,10'h020, 1,0,10'h020,0, 1,32'h0};
        vecs[10] = '{1,0,10'h010,32'h0,        1,10'h020, 0,0,10'h010,1, 1,32'hDEADBEEF};
        vecs[11] = '{0,0,10'h000,32'h0,        0,10'h000, 0,0,10'h000,0, 0,32'h0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset debugAck", {31'd0, bus.debugAck}, 32'd0);
        check("reset debugResult", bus.debugResult, 32'd0);
        check("reset clearBusy", {31'd0, bus.clearBusy}, 32'd0);
        check("reset ramStore", {31'd0, bus.ramStore}, 32'd0);
        rst = 1'b0;
        mem_init = 1'b0;

        // CPU, debug handshake, starvation
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bus.cpuRequest   = vecs[i].creq;
            bus.cpuStore     = vecs[i].cst;
            bus.cpuAddress   = vecs[i].caddr;
            bus.cpuData      = vecs[i].cdata;
            bus.debugRequest = vecs[i].dreq;
            bus.debugAddress = vecs[i].daddr;
            bus.clearStart   = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d stall", i), {31'd0, bus.cpuStall}, {31'd0, vecs[i].e_stall});
            check($sformatf("vec%0d store", i), {31'd0, bus.ramStore}, {31'd0, vecs[i].e_store});
            check($sformatf("vec%0d addr", i), {22'd0, bus.ramAddress}, {22'd0, vecs[i].e_raddr});
            check($sformatf("vec%0d ack", i), {31'd0, bus.debugAck}, {31'd0, vecs[i].e_ack});
            if (vecs[i].chk_res)
                check($sformatf("vec%0d result", i), bus.cpuResult, vecs[i].e_res);
            if (i == 4)
                check("debugResult held", bus.debugResult, 32'hDEADBEEF);
        end
        check("debugResult after starve", bus.debugResult, 32'h0);

        // bulk clear
        cpu_store(10'h000, 32'h12345678);
        cpu_store(10'h3FC, 32'h12345678);
        @(posedge clk); #1;
        idle_inputs();
        bus.clearStart = 1'b1;
        @(negedge clk);
        check("clear start busy", {31'd0, bus.clearBusy}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        wait_clear("clear1");
        cpu_read(10'h000, 32'h0);
        cpu_read(10'h3FC, 32'h0);
        cpu_read(10'h100, 32'h0);

        // reset mid-clear, with a CPU store held during reset
        cpu_store(10'h0C8, 32'hA5A5A5A5);
        cpu_store(10'h320, 32'hA5A5A5A5);
        @(posedge clk); #1;
        idle_inputs();
        bus.clearStart = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        repeat (100) @(posedge clk);
        #1;
        bus.cpuRequest = 1'b1; bus.cpuStore = 1'b1; bus.cpuAddress = 10'h320; bus.cpuData = 32'h0;
        rst = 1'b1;
        #1;
        check("midclear busy", {31'd0, bus.clearBusy}, 32'd0);
        check("midclear ack", {31'd0, bus.debugAck}, 32'd0);
        check("midclear store", {31'd0, bus.ramStore}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        cpu_read(10'h0C8, 32'h0);
        cpu_read(10'h320, 32'hA5A5A5A5);

        // clearStart collides with a CPU store to the last word
        @(posedge clk); #1;
        idle_inputs();
        bus.cpuRequest = 1'b1; bus.cpuStore = 1'b1; bus.cpuAddress = 10'h3FC;
        bus.cpuData = 32'hCAFEF00D; bus.clearStart = 1'b1;
        @(negedge clk);
        check("collide stall", {31'd0, bus.cpuStall}, 32'd0);
        check("collide store", {31'd0, bus.ramStore}, 32'd1);
        check("collide addr", {22'd0, bus.ramAddress}, 32'h3FC);
        @(posedge clk); #1;
        idle_inputs();
        check("collide written", mem[255], 32'hCAFEF00D);
        wait_clear("clear2");
        cpu_read(10'h3FC, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single data RAM between three requesters:
  - the CPU memory stage (load/store);
  - a debug inspection port (word reads for the 7-segment display);
  - an internal bulk-clear engine.
- Replaces the fixed address mux in front of the RAM.
- Stalls the pipeline through cpuStall, which is ANDed into the global pipeline enable.
- Sits between the EX/ME pipe register outputs and the Ram instance.

Parameters:
ADDR_WIDTH, 10, byte-address width of RAM; word index = address[ADDR_WIDTH-1:2]
DEPTH, 256, number of 32-bit words (2^(ADDR_WIDTH-2))
STARVE_LIMIT, 4, cycles a pending debug read waits before it pre-empts the CPU

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high
cpuRequest  in  1  ME stage performs a RAM access this cycle
cpuStore  in  1  1 = write, 0 = read (meaningful with cpuRequest)
cpuAddress  in  ADDR_WIDTH  byte address from ME stage
cpuData  in  32  store data
cpuResult  out  32  read word to ME stage (combinational from ramResult)
cpuStall  out  1  CPU access not served this cycle; pipeline must hold
debugRequest  in  1  debug read request, level, held until debugAck
debugAddress  in  ADDR_WIDTH  debug byte address
debugAck  out  1  one-cycle pulse, debugResult valid
debugResult  out  32  captured read word, held until next ack
clearStart  in  1  pulse: zero the whole RAM
clearBusy  out  1  clear in progress
ramStore  out  1  RAM write enable
ramAddress  out  ADDR_WIDTH  RAM byte address
ramData  out  32  RAM write data
ramResult  in  32  RAM combinational read data

Behaviour:
- Reset values:
  - state = SERVE; clearCount = 0; waitCount = 0.
  - debugAck = 0; debugResult = 0; clearBusy = 0.
  - ramStore = 0 while reset is asserted.
- States:
  - SERVE: clearStart = 1 -> CLEAR on the next edge.
  - CLEAR: clearCount == DEPTH-1 -> SERVE on the next edge. clearStart is ignored in CLEAR.
- Grant is combinational each cycle. Priority order:
  - CLEAR state: grant = CLEAR.
  - else if debugRequest && !debugAck && waitCount == STARVE_LIMIT: grant = DEBUG.
  - else if cpuRequest: grant = CPU.
  - else if debugRequest && !debugAck: grant = DEBUG.
  - else: grant = NONE.
- RAM drive per grant:
  - CPU: ramAddress = cpuAddress, ramStore = cpuStore, ramData = cpuData.
  - DEBUG: ramAddress = debugAddress, ramStore = 0.
  - CLEAR: ramAddress = {clearCount, 2'b00}, ramStore = 1, ramData = 0.
  - NONE: ramStore = 0, ramAddress = 0.
- cpuStall = cpuRequest && grant != CPU. Combinational, no latency.
- cpuResult = ramResult every cycle. The CPU samples it only when not stalled.
- Debug handshake:
  - On the grant cycle, ramResult is registered into debugResult.
  - debugAck = 1 on the following cycle only: latency 1 from grant, pulse width 1.
  - No debug grant is issued while debugAck = 1, so a request still high in the ack cycle is not served twice (minimum 2 cycles between debug grants).
- waitCount:
  - Increments while debugRequest = 1 and the debug port is not granted.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on a debug grant or when debugRequest = 0.
  - Keeps counting (saturating) during CLEAR.
- Clear engine:
  - One word per cycle; the whole clear takes exactly DEPTH cycles.
  - clearBusy = 1 for exactly those cycles.
  - clearCount increments in CLEAR, wraps to 0 on exit.
- CPU store with simultaneous clearStart: the store is served in that cycle; CLEAR starts on the next edge.
- Reset mid-clear: returns to SERVE immediately. RAM stays partially cleared; no recovery.
- Same-cycle CPU and debug requests below the starvation limit: CPU wins, debug waits.

Decomposition:
- Shared package (cpu_pkg):
  - grant encoding localparams GRANT_NONE / GRANT_CPU / GRANT_DEBUG / GRANT_CLEAR (2 bits);
  - state encoding STATE_SERVE / STATE_CLEAR;
  - WORD_WIDTH = 32.
- One sub-module, ram_arbiter_clear: owns clearCount, clearBusy and the SERVE/CLEAR FSM.
- Grant logic, waitCount, and the debug capture register stay in the top.

Test Plan:
1. CPU only: cpuRequest = 1, cpuStore = 1, cpuAddress = 0x010, cpuData = 0xDEADBEEF, then a read of 0x010 -> cpuStall = 0 both cycles; ramStore = 1 in cycle 1; cpuResult = 0xDEADBEEF in cycle 2.
2. Debug only: debugRequest = 1, debugAddress = 0x010 held until ack -> grant in cycle 0; debugAck = 1 in cycle 1 only; debugResult = 0xDEADBEEF held after ack.
3. Starvation: cpuRequest held 1 continuously, debugRequest raised at cycle 0 -> CPU served in cycles 0-3; debug granted in cycle 4 with cpuStall = 1 that cycle only; debugAck in cycle 5; cpuStall = 0 in cycle 5.
4. Clear: preload words 0 and 255 = 0x12345678, pulse clearStart -> clearBusy = 1 for exactly 256 cycles; cpuStall = 1 for a cpuRequest during them; all words read back 0.
5. Reset mid-clear: assert reset at clear cycle 100 -> clearBusy = 0 and debugAck = 0 immediately (asynchronous); word 50 = 0, word 200 keeps its old value.
6. Collision: clearStart and a CPU store to 0x3FC in the same cycle -> store performed; CLEAR begins next edge; word 255 ends at 0.
